// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ command sources.
// Optional watchdog on the master transaction: define I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_wr_bit,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_nack,
  output logic                       rsp_timeout,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_wr_bit,
  output logic                       m_run,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic                       m_nack,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic                       arb_busy,
  output logic [2:0]                 dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic              pick_valid;
  logic              timed_out;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             rsp_to_r;

  // Zero throughout IDLE, so it reads 0 in the GRANT cycle and counts from there.
  always_ff @(posedge sys_clk) begin
    if (rst || state == S_IDLE) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign timed_out   = (state == S_LAUNCH || state == S_WAIT) &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_to_r;
`else
  assign timed_out   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      gnt       <= '0;
      done      <= '0;
      m_run     <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      m_wr_bit  <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      rsp_to_r  <= 1'b0;
`endif
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            win      <= pick;
            gnt      <= NUM_REQ'(1) << pick;
            m_addr   <= addr_arr[pick];
            m_data   <= data_arr[pick];
            m_wr_bit <= req_wr_bit[pick];
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          m_run  <= 1'b1;
          state  <= S_LAUNCH;
        end
        S_LAUNCH, S_WAIT: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (m_done) begin
            rsp_rdata <= m_rdata;
            rsp_nack  <= m_nack;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_to_r  <= 1'b0;
`endif
            done      <= gnt;
            m_run     <= 1'b0;
            state     <= S_RESP;
          end else if (timed_out) begin
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_to_r  <= 1'b1;
`endif
            done      <= gnt;
            m_run     <= 1'b0;
            state     <= S_RESP;
          end else if (state == S_LAUNCH && m_busy) begin
            m_run <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_RESP: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arb_busy  = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model and a behavioural I2C master.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_wr_bit, gnt, done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_rdata, m_data, m_rdata;
  logic [AW-1:0]   m_addr;
  logic            rsp_nack, rsp_timeout, m_wr_bit, m_run, m_busy, m_done, m_nack, arb_busy;
  logic [2:0]      dbg_state;

  i2c_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_wr_bit(req_wr_bit), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .m_addr(m_addr), .m_data(m_data),
    .m_wr_bit(m_wr_bit), .m_run(m_run), .m_busy(m_busy), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata), .arb_busy(arb_busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural master: busy after busy_dly, done pulse after done_dly.
  int        mm_phase = 0, mm_cnt = 0, mm_busy_dly = 2, mm_done_dly = 20;
  bit        mm_skip_busy = 0, mm_never_done = 0, mm_rand = 0;
  logic [7:0] mm_rdata_nx = '0;
  logic       mm_nack_nx  = 1'b0;

  // Scoreboard entries: {timeout, nack, rdata}.
  logic [9:0] exp_q[$];
  int         grants[$];

  // Reference model state.
  int rr_m = 0, cur_w = 0, grant_cyc = 0, done_cnt = 0, grant_cnt = 0;
  logic            busy_prev = 1'b0;
  logic [N-1:0]    s_req, s_wr;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_data;
  logic            s_rst;

  task automatic mm_finish();
    m_done  = 1'b1;
    m_rdata = mm_rdata_nx;
    m_nack  = mm_nack_nx;
    exp_q.push_back({1'b0, mm_nack_nx, mm_rdata_nx});
    mm_phase = 0;
  endtask

  task automatic master_model();
    if (s_rst) begin
      mm_phase = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
    end else begin
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end
      case (mm_phase)
        0: if (m_run) begin
          if (mm_rand) begin
            mm_busy_dly  = $urandom_range(1, 4);
            mm_done_dly  = $urandom_range(1, 10);
            mm_skip_busy = ($urandom_range(0, 5) == 0);
            mm_rdata_nx  = 8'($urandom);
            mm_nack_nx   = 1'($urandom_range(0, 1));
          end
          mm_phase = 1;
          mm_cnt   = mm_skip_busy ? mm_done_dly : mm_busy_dly;
        end
        1: begin
          mm_cnt--;
          if (mm_cnt <= 0) begin
            if (mm_skip_busy) mm_finish();
            else begin
              m_busy   = 1'b1;
              mm_phase = 2;
              mm_cnt   = mm_done_dly;
            end
          end
        end
        2: if (!mm_never_done) begin
          mm_cnt--;
          if (mm_cnt <= 0) mm_finish();
        end
        default: mm_phase = 0;
      endcase
    end
  endtask

  // Compare outputs with the round-robin rules and the response scoreboard.
  task automatic observe();
    int w;
    logic [9:0] e;
    if (s_rst) begin
      rr_m = 0;
      exp_q.delete();
    end else begin
      if (arb_busy && !busy_prev) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && s_req[(rr_m + k) % N]) w = (rr_m + k) % N;
        if (w < 0) check("grant_without_req", arb_busy, 0);
        else begin
          check("gnt", gnt, 32'(1) << w);
          check("m_addr", m_addr, s_addr[w*AW +: AW]);
          check("m_data", m_data, s_data[w*DW +: DW]);
          check("m_wr_bit", m_wr_bit, s_wr[w]);
          rr_m = (w + 1) % N;
          cur_w = w;
          grant_cyc = cyc;
          grants.push_back(w);
          grant_cnt++;
        end
      end
      if (done != 0) begin
        done_cnt++;
        if (exp_q.size() == 0) check("done_unexpected", done, 0);
        else begin
          e = exp_q.pop_front();
          check("done_vec", done, 32'(1) << cur_w);
          check("gnt_in_resp", gnt, 32'(1) << cur_w);
          check("rsp_rdata", rsp_rdata, e[7:0]);
          check("rsp_nack", rsp_nack, e[8]);
          check("rsp_timeout", rsp_timeout, e[9]);
        end
      end
    end
    busy_prev = arb_busy;
  endtask

  task automatic step();
    s_req = req; s_addr = req_addr; s_data = req_data; s_wr = req_wr_bit; s_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    master_model();
    @(negedge clk);
    observe();
  endtask

  task automatic set_cmd(input int i, input logic [7:0] a, input logic [7:0] d, input logic wr);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_wr_bit[i]        = wr;
  endtask

  task automatic wait_done(input int lim, output int d_cyc, output int md_cyc, output bit ok);
    ok = 0; d_cyc = -1; md_cyc = -1;
    for (int i = 0; i < lim; i++) begin
      step();
      if (m_done) md_cyc = cyc;
      if (done != 0) begin
        d_cyc = cyc;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    int d_cyc, md_cyc, exp_order[5];
    bit ok, gap, any_done;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0; req_wr_bit = '0;
    m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;

    // Reset values
    do_reset();
    check("rst_gnt_done", {gnt, done}, 0);
    check("rst_run_busy", {m_run, arb_busy}, 0);
    check("rst_rsp", {rsp_rdata, rsp_nack, rsp_timeout}, 0);
    check("rst_cmd", {m_addr, m_data, m_wr_bit}, 0);

    // Single write with fixed latency checks
    set_cmd(0, 8'h0A, 8'h05, 1'b0);
    mm_rdata_nx = 8'h3C; mm_nack_nx = 1'b0;
    req[0] = 1'b1;
    step();
    check("t2_grant_cycle_run", m_run, 0);
    check("t2_grant_cycle_busy", arb_busy, 1);
    step();
    check("t2_run_latency", m_run, 1);
    check("t2_m_addr", m_addr, 8'h0A);
    check("t2_m_data", m_data, 8'h05);
    wait_done(100, d_cyc, md_cyc, ok);
    check("t2_done_seen", ok, 1);
    check("t2_done_after_mdone", d_cyc - md_cyc, 1);
    check("t2_done0", done, 4'b0001);
    req[0] = 1'b0;
    step();
    check("t2_done_one_cycle", done, 0);
    check("t2_idle", arb_busy, 0);

    // Contention: all requesters held high
    do_reset();
    mm_busy_dly = 1; mm_done_dly = 3;
    for (int i = 0; i < N; i++) set_cmd(i, 8'(8'h10 + i), 8'(8'h80 + i), i[0]);
    grants.delete();
    req = 4'hF;
    gap = 0;
    for (int i = 0; i < 600 && grants.size() < 5; i++) begin
      step();
      if (gap) begin
        check("t3_gap_gnt", gnt, 0);
        gap = 0;
      end
      if (done != 0) gap = 1;
    end
    check("t3_count", grants.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) check("t3_order", grants[i], exp_order[i]);
    req = '0;
    for (int i = 0; i < 200 && arb_busy; i++) step();
    check("t3_drained", arb_busy, 0);

    // Read with NACK on requester 2
    set_cmd(2, 8'h51, 8'h00, 1'b1);
    mm_rdata_nx = 8'hA5; mm_nack_nx = 1'b1;
    req[2] = 1'b1;
    wait_done(100, d_cyc, md_cyc, ok);
    check("t4_done_seen", ok, 1);
    check("t4_done2", done, 4'b0100);
    check("t4_rdata", rsp_rdata, 8'hA5);
    check("t4_nack", rsp_nack, 1);
    req[2] = 1'b0;
    repeat (3) step();
    check("t4_rsp_hold", {rsp_rdata, rsp_nack}, {8'hA5, 1'b1});
    mm_nack_nx = 1'b0;

    // Reset in the middle of WAIT
    mm_busy_dly = 2; mm_done_dly = 20;
    set_cmd(0, 8'h22, 8'h33, 1'b0);
    req[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_busy && !m_run && arb_busy) begin
        ok = 1;
        break;
      end
    end
    check("t5_reached_wait", ok, 1);
    rst = 1'b1; req = '0;
    step();
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_run", m_run, 0);
    check("t5_rst_busy", arb_busy, 0);
    rst = 1'b0;
    any_done = 0;
    repeat (5) begin
      step();
      if (done != 0) any_done = 1;
    end
    check("t5_no_done", any_done, 0);
    set_cmd(1, 8'h44, 8'h55, 1'b1);
    req = 4'b0011;
    wait_done(100, d_cyc, md_cyc, ok);
    check("t5_rr_reset_winner", done, 4'b0001);
    req[0] = 1'b0;
    wait_done(100, d_cyc, md_cyc, ok);
    check("t5_req1_served", done, 4'b0010);
    req[1] = 1'b0;
    step();

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: master goes busy and never completes
    do_reset();
    mm_never_done = 1;
    set_cmd(3, 8'h70, 8'h71, 1'b0);
    req[3] = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    wait_done(200, d_cyc, md_cyc, ok);
    check("t6_done_seen", ok, 1);
    check("t6_latency", d_cyc - grant_cyc, TO);
    check("t6_timeout_flag", rsp_timeout, 1);
    req[3] = 1'b0;
    step();
    check("t6_idle", arb_busy, 0);
    mm_never_done = 0;
`endif

    // Randomized traffic
    do_reset();
    mm_rand = 1;
    grant_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && c < 2000 && $urandom_range(0, 3) == 0) begin
          set_cmd(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          req[i] = 1'b1;
        end
      end
      if (c >= 2000 && req == '0 && !arb_busy) break;
    end
    check("rand_drained", {req, arb_busy}, 0);
    check("rand_grants_vs_dones", grant_cnt, done_cnt);
    check("rand_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
